// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with load handshake, selectable bit order and gapless frames.
// Optional trailing parity bit is enabled by defining PISO_PARITY_EN.
module piso_stream #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] pin,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             busy,
    output logic             done,
    output logic             ovr
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    if (WIDTH < 2 || (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("piso_stream: WIDTH must be >= 2 and PARITY_ODD 0 or 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT
`ifdef PISO_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             sout_q;
    logic             ovr_q;
    logic             last_data;
    logic             frame_end;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             pbit;
`endif

    assign last_data = (state == SHIFT) && (cnt == CNT_LAST);
`ifdef PISO_PARITY_EN
    assign frame_end = (state == PARITY);
`else
    assign frame_end = last_data;
`endif
    assign ready  = (state == IDLE) || frame_end;
    assign accept = ld && ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                IDLE:  state_nxt = IDLE;
                SHIFT: begin
                    if (last_data) begin
`ifdef PISO_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = IDLE;
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Shift register holds the bits not yet placed on sout; the first bit goes straight out on load.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg  <= '0;
            cnt    <= '0;
            sout_q <= 1'b0;
            ovr_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            pbit   <= 1'b0;
`endif
        end else begin
            if (ld && !ready) begin
                ovr_q <= 1'b1;
            end
            if (accept) begin
                cnt <= '0;
                if (MSB_FIRST) begin
                    sout_q <= pin[WIDTH-1];
                    shreg  <= {pin[WIDTH-2:0], 1'b0};
                end else begin
                    sout_q <= pin[0];
                    shreg  <= {1'b0, pin[WIDTH-1:1]};
                end
`ifdef PISO_PARITY_EN
                pbit <= (^pin) ^ (PARITY_ODD != 0);
`endif
            end else if (state == SHIFT && !last_data) begin
                cnt <= cnt + 1'b1;
                if (MSB_FIRST) begin
                    sout_q <= shreg[WIDTH-1];
                    shreg  <= {shreg[WIDTH-2:0], 1'b0};
                end else begin
                    sout_q <= shreg[0];
                    shreg  <= {1'b0, shreg[WIDTH-1:1]};
                end
`ifdef PISO_PARITY_EN
            end else if (last_data) begin
                sout_q <= pbit;
`endif
            end else begin
                sout_q <= 1'b0;
            end
        end
    end

    assign sout       = sout_q;
    assign sout_valid = (state != IDLE);
    assign busy       = (state != IDLE);
    assign done       = frame_end;
    assign ovr        = ovr_q;

endmodule
